sort_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's 4-input compare-exchange sorting network.
- Sorts LANES unsigned or signed words per transaction using a Batcher odd-even merge network, with one register stage per network layer.
- Supports a per-transaction ascending/descending mode and valid/ready flow control with backpressure.
- Sits between a data producer and a consumer that needs ordered lanes (e.g. median/min/max extraction).

---
 rtl/sort_pipe_if.sv | 27 ++
 rtl/sort_pipe.sv | 123 ++++++++++++
 tb/tb_sort_pipe.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_pipe_if.sv
// Valid/ready bundle carrying unsorted lanes in and sorted lanes out.
// Latency: none, wires only.
// Backpressure: out_ready stalls the sorter, which then deasserts in_ready.
interface sort_pipe_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_desc;
    logic [LANES*WIDTH-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out_data;

    // Sorter side: consumes the input handshake, produces the output one.
    modport slave (
        input  in_valid, in_desc, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_desc, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sort_pipe.sv
// Batcher odd-even merge sorter over LANES words, ascending or descending per transaction.
// Latency: 3 cycles (LANES=4) or 6 cycles (LANES=8), one transaction per cycle.
// Backpressure: global stall while out_valid && !out_ready; in_ready = !out_valid || out_ready.
module sort_pipe #(
    parameter int WIDTH  = 8,
    parameter int LANES  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    sort_pipe_if.slave     bus,
    output logic           busy
);
    localparam int S  = (LANES == 8) ? 6 : 3;
    localparam int DW = LANES * WIDTH;

    if (!(LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("sort_pipe: LANES must be 4 or 8");
    end

    // Stage registers. The last stage carries no mode bit: sorting is finished
    // by then and nothing downstream consumes it.
    logic [S-1:0]  vld_q,  vld_d;
    logic [S-2:0]  desc_q, desc_d;
    logic [DW-1:0] dat_q [S];
    logic [DW-1:0] dat_d [S];

    logic          adv;
    logic [DW-1:0] lay_in   [S];
    logic [S-1:0]  lay_desc;

    function automatic logic less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED) return $signed(a) < $signed(b);
        else        return a < b;
    endfunction

    // Lane that lane i is paired with in layer s; i itself when it idles.
    function automatic int partner(input int s, input int i);
        int p;
        p = i;
        if (LANES == 4) begin
            case (s)
                0: p = i ^ 1;
                1: p = i ^ 2;
                2: if (i == 1) p = 2; else if (i == 2) p = 1;
                default: p = i;
            endcase
        end else begin
            case (s)
                0: p = i ^ 1;
                1: p = i ^ 2;
                2: if (i == 1 || i == 5) p = i + 1; else if (i == 2 || i == 6) p = i - 1;
                3: p = i ^ 4;
                4: if (i == 2 || i == 3) p = i + 2; else if (i == 4 || i == 5) p = i - 2;
                5: if (i == 1 || i == 3 || i == 5) p = i + 1;
                   else if (i == 2 || i == 4 || i == 6) p = i - 1;
                default: p = i;
            endcase
        end
        return p;
    endfunction

    // One network layer. Each lane decides independently whether to keep its
    // own word or take its partner's; ties keep values intact since a == b.
    function automatic logic [DW-1:0] layer(input int s, input logic [DW-1:0] x, input logic desc);
        logic [DW-1:0]    r;
        logic [WIDTH-1:0] a, b;
        logic             keep;
        int               p;
        r = x;
        for (int i = 0; i < LANES; i++) begin
            p = partner(s, i);
            if (p != i) begin
                a    = x[i*WIDTH +: WIDTH];
                b    = x[p*WIDTH +: WIDTH];
                keep = ((i < p) ^ desc) ? less(a, b) : less(b, a);
                r[i*WIDTH +: WIDTH] = keep ? a : b;
            end
        end
        return r;
    endfunction

    // Next-state: shift every stage through its layer when the pipe may advance, else hold.
    always_comb begin
        adv    = !vld_q[S-1] || bus.out_ready;
        vld_d  = vld_q;
        desc_d = desc_q;
        dat_d  = dat_q;

        lay_in[0]   = bus.in_data;
        lay_desc[0] = bus.in_desc;
        for (int k = 1; k < S; k++) begin
            lay_in[k]   = dat_q[k-1];
            lay_desc[k] = desc_q[k-1];
        end

        if (adv) begin
            vld_d  = {vld_q[S-2:0], bus.in_valid};
            desc_d = {desc_q[S-3:0], bus.in_desc};
            for (int k = 0; k < S; k++) begin
                dat_d[k] = layer(k, lay_in[k], lay_desc[k]);
            end
        end
    end

    // Stage registers; reset drops every in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            desc_q <= '0;
            for (int k = 0; k < S; k++) dat_q[k] <= '0;
        end else begin
            vld_q  <= vld_d;
            desc_q <= desc_d;
            for (int k = 0; k < S; k++) dat_q[k] <= dat_d[k];
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_q[S-1];
    assign bus.out_data  = dat_q[S-1];
    assign busy          = |vld_q;
endmodule

// File: tb/tb_sort_pipe.sv
// Bench for sort_pipe: three instances (4x8 unsigned, 4x8 signed, 8x16 unsigned).
// Latency: checks 3/6-cycle result timing against a plain sort model.
// Backpressure: drives out_ready low and random to exercise global stalls.
module tb_sort_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    sort_pipe_if #(.WIDTH(8),  .LANES(4)) if4u ();
    sort_pipe_if #(.WIDTH(8),  .LANES(4)) if4s ();
    sort_pipe_if #(.WIDTH(16), .LANES(8)) if8  ();
    logic busy4u, busy4s, busy8;

    sort_pipe #(.WIDTH(8),  .LANES(4), .SIGNED(1'b0)) dut4u (.clk(clk), .rst(rst), .bus(if4u.slave), .busy(busy4u));
    sort_pipe #(.WIDTH(8),  .LANES(4), .SIGNED(1'b1)) dut4s (.clk(clk), .rst(rst), .bus(if4s.slave), .busy(busy4s));
    sort_pipe #(.WIDTH(16), .LANES(8), .SIGNED(1'b0)) dut8  (.clk(clk), .rst(rst), .bus(if8.slave),  .busy(busy8));

    // Reference: interpret lanes as numbers, insertion-sort, emit in the requested order.
    function automatic logic [127:0] ref_sort(input logic [127:0] d, input int lanes, input int width,
                                              input bit sgn, input bit desc);
        longint v [8];
        longint t, mask;
        logic [127:0] r;
        mask = (longint'(1) << width) - 1;
        for (int i = 0; i < lanes; i++) begin
            v[i] = longint'((d >> (i*width)) & 128'(mask));
            if (sgn && v[i] >= (longint'(1) << (width-1))) v[i] -= (longint'(1) << width);
        end
        for (int i = 1; i < lanes; i++)
            for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
                t = v[j]; v[j] = v[j-1]; v[j-1] = t;
            end
        r = '0;
        for (int i = 0; i < lanes; i++)
            r |= 128'(v[desc ? lanes-1-i : i] & mask) << (i*width);
        return r;
    endfunction

    task automatic drive4u(input logic v, input logic d, input logic [31:0] x);
        if4u.in_valid = v; if4u.in_desc = d; if4u.in_data = x;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++; if (if4u.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid4: got %b want 0", if4u.out_valid); end
        n_tests++; if (busy4u !== 1'b0) begin n_fail++; $display("FAIL reset_busy4: got %b want 0", busy4u); end
        n_tests++; if (if4u.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data4: got %h want 0", if4u.out_data); end
        n_tests++; if (if4u.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready4: got %b want 1", if4u.in_ready); end
        n_tests++; if (if8.out_valid !== 1'b0 || busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_8lane: got vld=%b busy=%b want 0 0", if8.out_valid, busy8); end
        n_tests++; if (if4s.out_valid !== 1'b0 || busy4s !== 1'b0) begin n_fail++; $display("FAIL reset_signed: got vld=%b busy=%b want 0 0", if4s.out_valid, busy4s); end
    endtask

    // Ascending then descending on the same lanes, back to back.
    task automatic test_asc_desc();
        logic [31:0] in_x, exp_a, exp_d;
        logic        ev, eb;
        in_x  = {8'h10, 8'hFF, 8'h10, 8'h40};   // lanes 0..3 = 40,10,FF,10
        exp_a = {8'hFF, 8'h40, 8'h10, 8'h10};   // lanes 10,10,40,FF
        exp_d = {8'h10, 8'h10, 8'h40, 8'hFF};   // lanes FF,40,10,10
        @(posedge clk); #1;
        drive4u(1'b1, 1'b0, in_x);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (c == 1) drive4u(1'b1, 1'b1, in_x);
            else        drive4u(1'b0, 1'b0, 32'h0);
            @(negedge clk);
            ev = (c == 3 || c == 4);
            eb = (c <= 4);
            n_tests++; if (if4u.out_valid !== ev) begin n_fail++; $display("FAIL asc_desc_valid c=%0d: got %b want %b", c, if4u.out_valid, ev); end
            n_tests++; if (busy4u !== eb) begin n_fail++; $display("FAIL asc_desc_busy c=%0d: got %b want %b", c, busy4u, eb); end
            if (c == 3) begin
                n_tests++; if (if4u.out_data !== exp_a) begin n_fail++; $display("FAIL asc_result: got %h want %h", if4u.out_data, exp_a); end
            end
            if (c == 4) begin
                n_tests++; if (if4u.out_data !== exp_d) begin n_fail++; $display("FAIL desc_result: got %h want %h", if4u.out_data, exp_d); end
            end
        end
    endtask

    // Same lanes through the signed and the unsigned instance.
    task automatic test_signed();
        logic [31:0] in_x, exp_s, exp_u;
        in_x  = {8'hFF, 8'h00, 8'h80, 8'h7F};   // lanes 7F,80,00,FF
        exp_s = {8'h7F, 8'h00, 8'hFF, 8'h80};   // lanes 80,FF,00,7F
        exp_u = {8'hFF, 8'h80, 8'h7F, 8'h00};   // lanes 00,7F,80,FF
        @(posedge clk); #1;
        drive4u(1'b1, 1'b0, in_x);
        if4s.in_valid = 1'b1; if4s.in_desc = 1'b0; if4s.in_data = in_x;
        @(posedge clk); #1;
        drive4u(1'b0, 1'b0, 32'h0);
        if4s.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (if4s.out_valid !== 1'b1 || if4s.out_data !== exp_s) begin n_fail++; $display("FAIL signed_sort: got vld=%b %h want 1 %h", if4s.out_valid, if4s.out_data, exp_s); end
        n_tests++; if (if4u.out_valid !== 1'b1 || if4u.out_data !== exp_u) begin n_fail++; $display("FAIL unsigned_sort: got vld=%b %h want 1 %h", if4u.out_valid, if4u.out_data, exp_u); end
        @(posedge clk);
    endtask

    // Five random transactions with a 4-cycle consumer stall mid-stream.
    task automatic test_backpressure();
        logic [31:0]  dat [5];
        logic         dsc [5];
        logic [127:0] q [$];
        logic [127:0] exp_v;
        logic [31:0]  prev_dat;
        logic         prev_stall;
        int           sent, got;
        for (int i = 0; i < 5; i++) begin dat[i] = $urandom; dsc[i] = 1'($urandom_range(0, 1)); end
        sent = 0; got = 0; prev_stall = 1'b0; prev_dat = '0;
        for (int c = 0; c < 60 && got < 5; c++) begin
            @(posedge clk); #1;
            if (sent < 5) drive4u(1'b1, dsc[sent], dat[sent]);
            else          drive4u(1'b0, 1'b0, 32'h0);
            if4u.out_ready = !(c >= 4 && c <= 7);
            @(negedge clk);
            n_tests++; if (if4u.in_ready !== (!if4u.out_valid || if4u.out_ready)) begin n_fail++; $display("FAIL bp_in_ready c=%0d: got %b want %b", c, if4u.in_ready, !if4u.out_valid || if4u.out_ready); end
            if (prev_stall) begin
                n_tests++; if (if4u.out_valid !== 1'b1 || if4u.out_data !== prev_dat) begin n_fail++; $display("FAIL bp_hold c=%0d: got vld=%b %h want 1 %h", c, if4u.out_valid, if4u.out_data, prev_dat); end
            end
            if (if4u.out_valid && if4u.out_ready) begin
                n_tests++;
                if (q.size() == 0) begin n_fail++; $display("FAIL bp_extra_output c=%0d: got %h want none", c, if4u.out_data); end
                else begin
                    exp_v = q.pop_front();
                    if (128'(if4u.out_data) !== exp_v) begin n_fail++; $display("FAIL bp_data c=%0d: got %h want %h", c, if4u.out_data, exp_v[31:0]); end
                end
                got++;
            end
            if (if4u.in_valid && if4u.in_ready) begin
                q.push_back(ref_sort(128'(dat[sent]), 4, 8, 1'b0, dsc[sent]));
                sent++;
            end
            prev_stall = if4u.out_valid && !if4u.out_ready;
            prev_dat   = if4u.out_data;
        end
        @(posedge clk); #1;
        drive4u(1'b0, 1'b0, 32'h0);
        if4u.out_ready = 1'b1;
        n_tests++; if (got != 5 || q.size() != 0) begin n_fail++; $display("FAIL bp_count: got %0d outputs %0d pending want 5 0", got, q.size()); end
    endtask

    // Eight lanes: reversed input, then 1000 random vectors with random flow control.
    task automatic test_lanes8();
        logic [127:0] x, exp_v;
        logic [127:0] q [$];
        int           sent, got;
        logic         cur_desc;
        for (int i = 0; i < 8; i++) x[i*16 +: 16] = 16'(7 - i);
        for (int i = 0; i < 8; i++) exp_v[i*16 +: 16] = 16'(i);
        @(posedge clk); #1;
        if8.in_valid = 1'b1; if8.in_desc = 1'b0; if8.in_data = x; if8.out_ready = 1'b1;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_tests++; if (if8.out_valid !== 1'b0) begin n_fail++; $display("FAIL l8_early: got %b want 0", if8.out_valid); end
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (if8.out_valid !== 1'b1 || if8.out_data !== exp_v) begin n_fail++; $display("FAIL l8_reverse: got vld=%b %h want 1 %h", if8.out_valid, if8.out_data, exp_v); end
        repeat (2) @(posedge clk);

        sent = 0; got = 0;
        cur_desc = 1'b0;
        x = '0;
        for (int c = 0; c < 10000 && got < 1000; c++) begin
            @(posedge clk); #1;
            if (!if8.in_valid || if8.in_ready || sent >= 1000) begin
                for (int i = 0; i < 8; i++)
                    x[i*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
                cur_desc = 1'($urandom_range(0, 1));
            end
            if8.in_valid  = (sent < 1000) && ($urandom_range(0, 9) < 7);
            if8.in_desc   = cur_desc;
            if8.in_data   = x;
            if8.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (if8.out_valid && if8.out_ready) begin
                n_tests++;
                if (q.size() == 0) begin n_fail++; $display("FAIL l8_extra_output c=%0d: got %h want none", c, if8.out_data); end
                else begin
                    exp_v = q.pop_front();
                    if (if8.out_data !== exp_v) begin n_fail++; $display("FAIL l8_random c=%0d: got %h want %h", c, if8.out_data, exp_v); end
                end
                got++;
            end
            if (if8.in_valid && if8.in_ready) begin
                q.push_back(ref_sort(if8.in_data, 8, 16, 1'b0, if8.in_desc));
                sent++;
            end
        end
        @(posedge clk); #1;
        if8.in_valid = 1'b0; if8.out_ready = 1'b1;
        n_tests++; if (got != 1000 || q.size() != 0) begin n_fail++; $display("FAIL l8_count: got %0d outputs %0d pending want 1000 0", got, q.size()); end
    endtask

    // Reset with two transactions in flight, then a fresh transaction.
    task automatic test_reset_midflight();
        logic [31:0]  x;
        logic [127:0] exp_v;
        int           stale;
        if4u.out_ready = 1'b1;
        @(posedge clk); #1;
        drive4u(1'b1, 1'b0, $urandom);
        @(posedge clk); #1;
        drive4u(1'b1, 1'b1, $urandom);
        @(posedge clk); #1;
        drive4u(1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (busy4u !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b want 1", busy4u); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (if4u.out_valid !== 1'b0 || busy4u !== 1'b0) begin n_fail++; $display("FAIL mid_reset_clear: got vld=%b busy=%b want 0 0", if4u.out_valid, busy4u); end
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (if4u.out_valid) stale++;
        end
        n_tests++; if (stale != 0) begin n_fail++; $display("FAIL mid_stale: got %0d outputs want 0", stale); end
        x = $urandom;
        exp_v = ref_sort(128'(x), 4, 8, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive4u(1'b1, 1'b1, x);
        @(posedge clk); #1;
        drive4u(1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (if4u.out_valid !== 1'b1 || 128'(if4u.out_data) !== exp_v) begin n_fail++; $display("FAIL mid_after_reset: got vld=%b %h want 1 %h", if4u.out_valid, if4u.out_data, exp_v[31:0]); end
    endtask

    initial begin
        rst = 1'b1;
        if4u.in_valid = 1'b0; if4u.in_desc = 1'b0; if4u.in_data = '0; if4u.out_ready = 1'b1;
        if4s.in_valid = 1'b0; if4s.in_desc = 1'b0; if4s.in_data = '0; if4s.out_ready = 1'b1;
        if8.in_valid  = 1'b0; if8.in_desc  = 1'b0; if8.in_data  = '0; if8.out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_asc_desc();
        test_signed();
        test_backpressure();
        test_lanes8();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
